// File: rtl/gpio_event_capture_if.sv
// Register-side interface of the GPIO event capture block.
// Signal prefixes are from the capture block's point of view: i_* flow into
// it, o_* flow out of it. The CSR block (or a testbench) uses the master
// modport, the capture block uses the slave modport.
interface gpio_event_capture_if #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
);

  logic                  i_tick;      // one-cycle debounce sample strobe
  logic [NUM_CH-1:0]     i_gpio_in;   // raw asynchronous inputs
  logic [2*NUM_CH-1:0]   i_mode;      // [2i+1:2i]: 00 level, 01 rise, 10 fall, 11 both
  logic                  i_clr_stb;   // one-cycle clear strobe
  logic [NUM_CH-1:0]     i_clr_mask;  // channels cleared on i_clr_stb
  logic [NUM_CH-1:0]     i_irq_mask;  // channels allowed to raise o_irq
  logic [SEL_W-1:0]      i_cnt_sel;   // event counter readout select

  logic [NUM_CH-1:0]     o_state;     // debounced level
  logic [NUM_CH-1:0]     o_sticky;    // latched event flags
  logic                  o_irq;       // registered OR of sticky & mask
  logic [7:0]            o_cnt_out;   // registered count of channel i_cnt_sel

  modport master (
    output i_tick, i_gpio_in, i_mode, i_clr_stb, i_clr_mask, i_irq_mask, i_cnt_sel,
    input  o_state, o_sticky, o_irq, o_cnt_out
  );

  modport slave (
    input  i_tick, i_gpio_in, i_mode, i_clr_stb, i_clr_mask, i_irq_mask, i_cnt_sel,
    output o_state, o_sticky, o_irq, o_cnt_out
  );

endinterface

// File: rtl/gpio_event_capture.sv
// N-channel GPIO event capture: per channel a synchroniser, a tick-based
// debouncer, selectable edge/level event detection, a sticky flag with
// masked clear and a saturating 8-bit event counter. A masked OR of the
// sticky flags drives a registered interrupt, and one counter at a time can
// be read back through a registered select mux.
//
// The bus interface must be instantiated with the same NUM_CH and SEL_W as
// this module.
module gpio_event_capture #(
  parameter int NUM_CH         = 8,   // 1..16
  parameter int SEL_W          = 3,   // NUM_CH <= 2**SEL_W
  parameter int SYNC_STAGES    = 2,   // >= 2
  parameter int DEBOUNCE_TICKS = 16,  // 0 bypasses the debouncer
  parameter int CNT_W          = 8    // DEBOUNCE_TICKS < 2**CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gpio_event_capture_if.slave     bus
);

  localparam int                   EVT_CNT_W = 8;
  localparam logic [EVT_CNT_W-1:0] EVT_CNT_MAX = '1;

  // Synchroniser chain; index SYNC_STAGES-1 is the stage the debouncer sees.
  logic [NUM_CH-1:0]    r_sync [SYNC_STAGES];
  logic [NUM_CH-1:0]    w_sync;

  // Debounced level and its one-cycle delayed copy for edge detection.
  logic [NUM_CH-1:0]    r_state;
  logic [NUM_CH-1:0]    r_state_d;

  // Event flags and counters.
  logic [NUM_CH-1:0]    r_sticky;
  logic [EVT_CNT_W-1:0] r_cnt [NUM_CH];

  // Registered outputs.
  logic                 r_irq;
  logic [EVT_CNT_W-1:0] r_cnt_out;

  // Combinational per-channel qualifiers.
  logic [NUM_CH-1:0]    w_rise;
  logic [NUM_CH-1:0]    w_fall;
  logic [NUM_CH-1:0]    w_evt;
  logic [NUM_CH-1:0]    w_cnt_inc;
  logic [NUM_CH-1:0]    w_clr;
  logic [EVT_CNT_W-1:0] w_cnt_sel_val;

  // Bring the raw inputs into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every flop uses non-blocking assignment so all stages sample the
    // pre-edge value; blocking here would collapse the chain into one flop.
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= bus.i_gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_TICKS == 0) begin : g_bypass

      // Debounce bypassed: the debounced level follows the synchroniser.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= '0;
        end else begin
          r_state <= w_sync;
        end
      end

    end else begin : g_debounce

      localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

      // Consecutive mismatching ticks seen so far, per channel.
      logic [CNT_W-1:0] r_dcnt [NUM_CH];

      // Accept a new level only after DEBOUNCE_TICKS consecutive mismatching
      // ticks; any matching tick restarts the count, no tick holds it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= '0;
          for (int c = 0; c < NUM_CH; c++) begin
            r_dcnt[c] <= '0;
          end
        end else if (bus.i_tick) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (w_sync[c] != r_state[c]) begin
              if (r_dcnt[c] == DCNT_LAST) begin
                r_state[c] <= ~r_state[c];
                r_dcnt[c]  <= '0;
              end else begin
                r_dcnt[c]  <= r_dcnt[c] + 1'b1;
              end
            end else begin
              r_dcnt[c] <= '0;
            end
          end
        end
      end

    end
  endgenerate

  assign w_rise = r_state & ~r_state_d;
  assign w_fall = ~r_state & r_state_d;
  assign w_clr  = {NUM_CH{bus.i_clr_stb}} & bus.i_clr_mask;

  // Per-channel event and counter-increment selection from the mode field.
  // Level mode flags every cycle the level is high but counts only rises, so
  // the counter reflects distinct assertions rather than cycles held.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit; otherwise a
    // missing branch would infer a latch.
    w_evt     = '0;
    w_cnt_inc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (bus.i_mode[2*c +: 2])
        2'b00: begin
          w_evt[c]     = r_state[c];
          w_cnt_inc[c] = w_rise[c];
        end
        2'b01: begin
          w_evt[c]     = w_rise[c];
          w_cnt_inc[c] = w_rise[c];
        end
        2'b10: begin
          w_evt[c]     = w_fall[c];
          w_cnt_inc[c] = w_fall[c];
        end
        default: begin
          w_evt[c]     = w_rise[c] | w_fall[c];
          w_cnt_inc[c] = w_rise[c] | w_fall[c];
        end
      endcase
    end
  end

  // Sticky flags and counters. An event arriving together with a clear
  // survives it: the flag stays set and the counter restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the counter array is a bank of flops, not a RAM, so it is reset
    // with everything else rather than left undefined.
    if (!rst_n) begin
      r_state_d <= '0;
      r_sticky  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= '0;
      end
    end else begin
      r_state_d <= r_state;
      r_sticky  <= (r_sticky & ~w_clr) | w_evt;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_clr[c]) begin
          r_cnt[c] <= EVT_CNT_W'(w_cnt_inc[c]);
        end else if (w_cnt_inc[c] && (r_cnt[c] != EVT_CNT_MAX)) begin
          r_cnt[c] <= r_cnt[c] + 1'b1;
        end
      end
    end
  end

  // Counter readout mux; selects beyond the last channel read as zero.
  always_comb begin
    w_cnt_sel_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.i_cnt_sel == SEL_W'(c)) begin
        w_cnt_sel_val = r_cnt[c];
      end
    end
  end

  // Register the interrupt and the counter readout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq     <= 1'b0;
      r_cnt_out <= '0;
    end else begin
      r_irq     <= |(r_sticky & bus.i_irq_mask);
      r_cnt_out <= w_cnt_sel_val;
    end
  end

  assign bus.o_state   = r_state;
  assign bus.o_sticky  = r_sticky;
  assign bus.o_irq     = r_irq;
  assign bus.o_cnt_out = r_cnt_out;

endmodule

// File: tb/tb_gpio_event_capture.sv
// Self-checking bench for gpio_event_capture: a cycle table for debounce,
// glitch rejection and clear, hand sequences for the multi-cycle corner
// cases, and a randomized run against a behavioural reference model.
module tb_gpio_event_capture;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 4;
  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int CNT_W  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #4 clk = ~clk;

  gpio_event_capture_if #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

  gpio_event_capture #(
    .NUM_CH        (NUM_CH),
    .SEL_W         (SEL_W),
    .SYNC_STAGES   (SYNC),
    .DEBOUNCE_TICKS(DEB),
    .CNT_W         (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Tick generation and cycle stepping (inputs change on the falling edge)
  // ---------------------------------------------------------------------
  bit auto_tick   = 1'b0;
  int tick_period = 10;
  int tick_ctr    = 0;

  task automatic cycle();
    @(negedge clk);
    if (auto_tick) begin
      tick_ctr   = (tick_ctr + 1 >= tick_period) ? 0 : tick_ctr + 1;
      bus.i_tick = (tick_ctr == 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    bus.i_tick     = 1'b0;
    bus.i_gpio_in  = '0;
    bus.i_mode     = '0;
    bus.i_clr_stb  = 1'b0;
    bus.i_clr_mask = '0;
    bus.i_irq_mask = '0;
    bus.i_cnt_sel  = '0;
    tick_ctr       = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  // Reference model: input delay line, run-length debounce, events derived
  // from old/new level, counters as saturating integers.
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0] m_pipe [$];
  logic [NUM_CH-1:0] m_state, m_prev, m_sticky;
  int                m_run [NUM_CH];
  int                m_cnt [NUM_CH];
  logic              m_irq;
  logic [7:0]        m_cnt_out;

  task automatic model_reset();
    m_pipe = {};
    for (int s = 0; s < SYNC; s++) m_pipe.push_back('0);
    m_state   = '0;
    m_prev    = '0;
    m_sticky  = '0;
    m_irq     = 1'b0;
    m_cnt_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_run[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] sync_now;
    logic [NUM_CH-1:0] new_state;
    logic [NUM_CH-1:0] new_sticky;
    int                sel;
    bit                rose, fell, ev, counts, clear;

    sync_now = m_pipe[0];
    void'(m_pipe.pop_front());
    m_pipe.push_back(bus.i_gpio_in);

    sel       = int'(bus.i_cnt_sel);
    m_irq     = |(m_sticky & bus.i_irq_mask);
    m_cnt_out = (sel < NUM_CH) ? 8'(m_cnt[sel]) : 8'd0;

    new_state  = m_state;
    new_sticky = m_sticky;
    for (int i = 0; i < NUM_CH; i++) begin
      rose  = m_state[i] && !m_prev[i];
      fell  = !m_state[i] && m_prev[i];
      clear = bus.i_clr_stb && bus.i_clr_mask[i];
      case (bus.i_mode[2*i +: 2])
        2'b00:   begin ev = m_state[i];   counts = rose; end
        2'b01:   begin ev = rose;         counts = rose; end
        2'b10:   begin ev = fell;         counts = fell; end
        default: begin ev = rose || fell; counts = ev;   end
      endcase
      new_sticky[i] = ev || (m_sticky[i] && !clear);
      if (clear) m_cnt[i] = counts ? 1 : 0;
      else if (counts) m_cnt[i] = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;

      if (bus.i_tick) begin
        if (sync_now[i] != m_state[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            new_state[i] = ~m_state[i];
            m_run[i]     = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    m_prev   = m_state;
    m_state  = new_state;
    m_sticky = new_sticky;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------------------------------------------------------------
  // Cycle table: ch0 in rise mode, tick driven per row, clear mask ch0.
  // ---------------------------------------------------------------------
  typedef struct {
    logic [7:0] gpio;
    logic       tick;
    logic       clr;
    logic [7:0] e_state;
    logic [7:0] e_sticky;
    logic       e_irq;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic [7:0] g, logic t, logic c,
                              logic [7:0] st, logic [7:0] sk, logic irq, logic [7:0] cn);
    vec_t v;
    v.gpio = g; v.tick = t; v.clr = c;
    v.e_state = st; v.e_sticky = sk; v.e_irq = irq; v.e_cnt = cn;
    return v;
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic t_was;
  int   ticks;
  bit   rose_seen;
  int   idx;

  initial begin
    // Row: gpio tick clr | state sticky irq cnt_out
    tbl.push_back(mk(8'h01, 1, 0, 8'h00, 8'h00, 0, 8'd0));
    tbl.push_back(mk(8'h01, 1, 0, 8'h00, 8'h00, 0, 8'd0));
    tbl.push_back(mk(8'h01, 1, 0, 8'h00, 8'h00, 0, 8'd0));
    tbl.push_back(mk(8'h01, 1, 0, 8'h00, 8'h00, 0, 8'd0));
    tbl.push_back(mk(8'h01, 1, 0, 8'h00, 8'h00, 0, 8'd0));
    tbl.push_back(mk(8'h01, 1, 0, 8'h01, 8'h00, 0, 8'd0));
    tbl.push_back(mk(8'h01, 1, 0, 8'h01, 8'h01, 0, 8'd0));
    tbl.push_back(mk(8'h01, 1, 0, 8'h01, 8'h01, 1, 8'd1));
    tbl.push_back(mk(8'h00, 0, 0, 8'h01, 8'h01, 1, 8'd1));
    tbl.push_back(mk(8'h00, 0, 0, 8'h01, 8'h01, 1, 8'd1));
    tbl.push_back(mk(8'h01, 1, 0, 8'h01, 8'h01, 1, 8'd1));
    tbl.push_back(mk(8'h00, 1, 0, 8'h01, 8'h01, 1, 8'd1));
    tbl.push_back(mk(8'h00, 1, 0, 8'h01, 8'h01, 1, 8'd1));
    tbl.push_back(mk(8'h00, 1, 0, 8'h01, 8'h01, 1, 8'd1));
    tbl.push_back(mk(8'h00, 0, 0, 8'h01, 8'h01, 1, 8'd1));
    tbl.push_back(mk(8'h00, 1, 0, 8'h01, 8'h01, 1, 8'd1));
    tbl.push_back(mk(8'h00, 1, 0, 8'h01, 8'h01, 1, 8'd1));
    tbl.push_back(mk(8'h00, 1, 0, 8'h00, 8'h01, 1, 8'd1));
    tbl.push_back(mk(8'h00, 0, 1, 8'h00, 8'h00, 1, 8'd1));
    tbl.push_back(mk(8'h00, 0, 0, 8'h00, 8'h00, 0, 8'd0));

    // Reset state
    do_reset();
    check("rst.state",  bus.o_state,   8'h00);
    check("rst.sticky", bus.o_sticky,  8'h00);
    check("rst.irq",    bus.o_irq,     1'b0);
    check("rst.cnt",    bus.o_cnt_out, 8'h00);

    // Table run
    auto_tick      = 1'b0;
    bus.i_mode     = 16'h0001;
    bus.i_clr_mask = 8'h01;
    bus.i_irq_mask = 8'h01;
    bus.i_cnt_sel  = '0;
    for (int k = 0; k < tbl.size(); k++) begin
      bus.i_gpio_in = tbl[k].gpio;
      bus.i_tick    = tbl[k].tick;
      bus.i_clr_stb = tbl[k].clr;
      @(negedge clk);
      check($sformatf("tbl%0d.state", k),  bus.o_state,   tbl[k].e_state);
      check($sformatf("tbl%0d.sticky", k), bus.o_sticky,  tbl[k].e_sticky);
      check($sformatf("tbl%0d.irq", k),    bus.o_irq,     tbl[k].e_irq);
      check($sformatf("tbl%0d.cnt", k),    bus.o_cnt_out, tbl[k].e_cnt);
    end

    // Held input accepted on the 4th tick after the synchroniser sees it
    do_reset();
    auto_tick = 1'b1; tick_period = 10; tick_ctr = 0;
    bus.i_mode = 16'h0001; bus.i_irq_mask = 8'hFF; bus.i_cnt_sel = '0;
    bus.i_gpio_in = 8'h01;
    ticks = 0; rose_seen = 0; idx = 0;
    while (idx < 200 && !rose_seen) begin
      t_was = bus.i_tick;
      cycle();
      if (idx >= SYNC && t_was) ticks++;
      if (bus.o_state[0]) rose_seen = 1;
      idx++;
    end
    check("t1.rose",       32'(rose_seen), 1);
    check("t1.ticks",      ticks, 4);
    check("t1.sticky_lag", bus.o_sticky, 8'h00);
    cycle();
    check("t1.sticky",     bus.o_sticky, 8'h01);
    check("t1.irq_lag",    bus.o_irq, 1'b0);
    cycle();
    check("t1.irq",        bus.o_irq, 1'b1);
    check("t1.cnt",        bus.o_cnt_out, 8'd1);
    repeat (40) cycle();
    check("t1.hold_state", bus.o_state, 8'h01);
    check("t1.hold_cnt",   bus.o_cnt_out, 8'd1);

    // Glitch lasting three ticks is rejected
    do_reset();
    auto_tick = 1'b1; tick_period = 10; tick_ctr = 0;
    bus.i_mode = 16'h0003; bus.i_irq_mask = 8'hFF;
    bus.i_gpio_in = 8'h01;
    repeat (30) cycle();
    bus.i_gpio_in = 8'h00;
    repeat (60) cycle();
    check("t2.state",  bus.o_state,   8'h00);
    check("t2.sticky", bus.o_sticky,  8'h00);
    check("t2.irq",    bus.o_irq,     1'b0);
    check("t2.cnt",    bus.o_cnt_out, 8'd0);

    // Counter saturation on ch1 in both-edge mode
    do_reset();
    auto_tick = 1'b1; tick_period = 1; tick_ctr = 0;
    bus.i_mode = 16'h000D; bus.i_cnt_sel = 4'd1; bus.i_irq_mask = 8'h00;
    bus.i_gpio_in = 8'h01;
    repeat (10) cycle();
    for (int n = 1; n <= 300; n++) begin
      bus.i_gpio_in[1] = ~bus.i_gpio_in[1];
      repeat (8) cycle();
      if (n == 100) check("t3.cnt100", bus.o_cnt_out, 8'd100);
      if (n == 254) check("t3.cnt254", bus.o_cnt_out, 8'd254);
    end
    check("t3.sat",    bus.o_cnt_out, 8'd255);
    check("t3.state",  bus.o_state,   8'h01);
    check("t3.sticky", bus.o_sticky,  8'h03);
    bus.i_cnt_sel = 4'd0;
    cycle();
    check("t3.sel0",   bus.o_cnt_out, 8'd1);
    bus.i_cnt_sel = 4'd1;
    cycle();
    check("t3.sel1",   bus.o_cnt_out, 8'd255);

    // Clear coinciding with a new ch1 event: flag kept, count restarts at 1
    bus.i_gpio_in[1] = 1'b1;
    repeat (6) cycle();
    check("t4.pre_state", bus.o_state, 8'h03);
    bus.i_clr_stb = 1'b1; bus.i_clr_mask = 8'h02;
    cycle();
    bus.i_clr_stb = 1'b0; bus.i_clr_mask = 8'h00;
    check("t4.sticky", bus.o_sticky, 8'h03);
    cycle();
    check("t4.cnt1",   bus.o_cnt_out, 8'd1);
    bus.i_cnt_sel = 4'd0;
    cycle();
    check("t4.cnt0",   bus.o_cnt_out, 8'd1);

    // Interrupt masking
    bus.i_irq_mask = 8'h04;
    cycle(); cycle();
    check("t5.irq_off", bus.o_irq, 1'b0);
    bus.i_irq_mask = 8'h01;
    cycle();
    check("t5.irq_on",  bus.o_irq, 1'b1);

    // Asynchronous reset mid-debounce
    bus.i_mode = 16'h0000; bus.i_gpio_in = 8'hFF; bus.i_irq_mask = 8'hFF;
    repeat (10) cycle();
    check("t6.pre_sticky", bus.o_sticky, 8'hFF);
    check("t6.pre_irq",    bus.o_irq,    1'b1);
    bus.i_gpio_in = 8'h00;
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    check("t6.state",  bus.o_state,   8'h00);
    check("t6.sticky", bus.o_sticky,  8'h00);
    check("t6.irq",    bus.o_irq,     1'b0);
    check("t6.cnt",    bus.o_cnt_out, 8'd0);
    bus.i_gpio_in = 8'h01;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cycle();
    check("t6.no_early_rise", bus.o_state,  8'h00);
    check("t6.no_event",      bus.o_sticky, 8'h00);
    cycle();
    check("t6.full_debounce", bus.o_state,  8'h01);

    // Randomized run against the reference model
    do_reset();
    auto_tick = 1'b0;
    for (int n = 0; n < 3000 && errors < 20; n++) begin
      int bit_idx;
      bus.i_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) begin
        bit_idx = int'($urandom_range(0, NUM_CH - 1));
        bus.i_gpio_in = bus.i_gpio_in ^ (8'h01 << bit_idx);
      end
      if ($urandom_range(0, 49) == 0) bus.i_mode = 16'($urandom);
      bus.i_clr_stb  = ($urandom_range(0, 15) == 0);
      bus.i_clr_mask = 8'($urandom);
      if ($urandom_range(0, 19) == 0) bus.i_irq_mask = 8'($urandom);
      if ($urandom_range(0, 3) == 0)  bus.i_cnt_sel  = 4'($urandom);
      @(negedge clk);
      check("rnd.state",  bus.o_state,   m_state);
      check("rnd.sticky", bus.o_sticky,  m_sticky);
      check("rnd.irq",    bus.o_irq,     m_irq);
      check("rnd.cnt",    bus.o_cnt_out, m_cnt_out);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
